// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// clear-engine state encoding and packed-port slicing helper.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NREG       = 2**DEF_ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // LSB position of port 'port' inside a packed bus of 'width'-bit fields
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks every clearable register index once and
// reports progress through clr_busy / clr_done.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_idx
);

    localparam logic [ADDR_W-1:0] START_IDX = (ZERO_REG != 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};

    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_clr_done;
    logic              w_done_nxt;

    // Next-state, index and completion-pulse logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = START_IDX;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CLEAR: begin
                w_idx_nxt = r_idx + ADDR_W'(1);
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = CLEAR;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, index and done-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= {ADDR_W{1'b0}};
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_clr_done <= w_done_nxt;
        end
    end

    assign o_clr_busy = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_idx  = r_idx;
    assign o_clr_done = r_clr_done;

endmodule

// File: rtl/regfile_mp.sv
// Integer register file with NREAD combinational read ports, two write ports,
// optional write-to-read bypass, busy scoreboard and hardware clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*ADDR_W-1:0] i_rd_addr,
    output logic [NREAD*DATA_W-1:0] o_rd_data,
    output logic [NREAD-1:0]        o_rd_busy,
    input  logic                    i_wa_en,
    input  logic [ADDR_W-1:0]       i_wa_addr,
    input  logic [DATA_W-1:0]       i_wa_data,
    input  logic                    i_wb_en,
    input  logic [ADDR_W-1:0]       i_wb_addr,
    input  logic [DATA_W-1:0]       i_wb_data,
    input  logic                    i_sb_set_en,
    input  logic [ADDR_W-1:0]       i_sb_set_addr,
    input  logic                    i_clr_req,
    output logic                    o_clr_busy,
    output logic                    o_clr_done
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                w_clr_we;
    logic [ADDR_W-1:0]   w_clr_idx;
    logic                w_wa_ok;
    logic                w_wb_ok;
    logic                w_set_ok;

    regfile_clr_fsm #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr_req  (i_clr_req),
        .o_clr_busy (o_clr_busy),
        .o_clr_done (o_clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_idx  (w_clr_idx)
    );

    // Register 0 is never written or marked busy when hardwired to zero
    assign w_wa_ok  = i_wa_en     && !((ZERO_REG != 0) && (i_wa_addr     == {ADDR_W{1'b0}}));
    assign w_wb_ok  = i_wb_en     && !((ZERO_REG != 0) && (i_wb_addr     == {ADDR_W{1'b0}}));
    assign w_set_ok = i_sb_set_en && !((ZERO_REG != 0) && (i_sb_set_addr == {ADDR_W{1'b0}}));

    // Storage and scoreboard update; port A written last so it wins a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
            r_busy <= {NUM_REGS{1'b0}};
        end else if (w_clr_we) begin
            r_mem[w_clr_idx]  <= {DATA_W{1'b0}};
            r_busy[w_clr_idx] <= 1'b0;
        end else begin
            if (w_wb_ok) begin
                r_mem[i_wb_addr] <= i_wb_data;
            end
            if (w_wa_ok) begin
                r_mem[i_wa_addr] <= i_wa_data;
            end
            if (i_wb_en) begin
                r_busy[i_wb_addr] <= 1'b0;
            end
            if (w_set_ok) begin
                r_busy[i_sb_set_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = i_rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];

        // Read mux: zero register, then bypass (outside clear), then storage
        always_comb begin
            w_data = r_mem[w_addr];
            w_busy = r_busy[w_addr];
            if ((ZERO_REG != 0) && (w_addr == {ADDR_W{1'b0}})) begin
                w_data = {DATA_W{1'b0}};
                w_busy = 1'b0;
            end else if ((BYPASS != 0) && !w_clr_we) begin
                if (i_wa_en && (i_wa_addr == w_addr)) begin
                    w_data = i_wa_data;
                end else if (i_wb_en && (i_wb_addr == w_addr)) begin
                    w_data = i_wb_data;
                end else begin
                    w_data = r_mem[w_addr];
                end
                if (i_wb_en && (i_wb_addr == w_addr)) begin
                    w_busy = 1'b0;
                end else begin
                    w_busy = r_busy[w_addr];
                end
            end else begin
                w_data = r_mem[w_addr];
                w_busy = r_busy[w_addr];
            end
        end

        assign o_rd_data[port_lsb(k, DATA_W) +: DATA_W] = w_data;
        assign o_rd_busy[k] = w_busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with a read-expectation queue.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic            wa_en = 1'b0, wb_en = 1'b0, sb_set_en = 1'b0, clr_req = 1'b0;
    logic [AW-1:0]   wa_addr = '0, wb_addr = '0, sb_set_addr = '0;
    logic [DW-1:0]   wa_data = '0, wb_data = '0;
    logic            clr_busy, clr_done;

    typedef struct {
        string         tag;
        int            port;
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_rd_busy     (rd_busy),
        .i_wa_en       (wa_en),
        .i_wa_addr     (wa_addr),
        .i_wa_data     (wa_data),
        .i_wb_en       (wb_en),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_data),
        .i_sb_set_en   (sb_set_en),
        .i_sb_set_addr (sb_set_addr),
        .i_clr_req     (clr_req),
        .o_clr_busy    (clr_busy),
        .o_clr_done    (clr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int port, input logic [DW-1:0] d, input logic b);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.data = d;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, "_data"}, 64'(rd_data[e.port*DW +: DW]), 64'(e.data));
            chk({e.tag, "_busy"}, 64'(rd_busy[e.port]), 64'(e.busy));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic idle_in();
        wa_en = 1'b0;
        wb_en = 1'b0;
        sb_set_en = 1'b0;
        clr_req = 1'b0;
    endtask

    initial begin
        int k;
        logic [AW-1:0] a;

        // reset state
        set_rd(0, 5'd5);
        set_rd(1, 5'd31);
        push("reset_p0", 0, 32'h0, 1'b0);
        push("reset_p1", 1, 32'h0, 1'b0);
        drain();
        chk("reset_clr_busy", 64'(clr_busy), 64'd0);
        chk("reset_clr_done", 64'(clr_done), 64'd0);
        #1 rst_n = 1'b1;
        tick();

        // dual write collision on reg 5
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hAAAA0000;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555FFFF;
        set_rd(0, 5'd5);
        push("collide_bypass", 0, 32'hAAAA0000, 1'b0);
        drain();
        tick();
        idle_in();
        push("collide_stored", 0, 32'hAAAA0000, 1'b0);
        drain();

        // zero register
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hDEADBEEF;
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        set_rd(0, 5'd0);
        push("zero_same", 0, 32'h0, 1'b0);
        drain();
        tick();
        idle_in();
        push("zero_after", 0, 32'h0, 1'b0);
        drain();

        // scoreboard set on 7, then clear via wb
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        set_rd(1, 5'd7);
        push("sb7_same", 1, 32'h0, 1'b0);
        drain();
        tick();
        idle_in();
        push("sb7_next", 1, 32'h0, 1'b1);
        drain();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12;
        push("wb7_bypass", 1, 32'h12, 1'b0);
        drain();
        tick();
        idle_in();
        push("wb7_stored", 1, 32'h12, 1'b0);
        drain();

        // set and clear on the same register: set wins
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        set_rd(1, 5'd9);
        push("sb9_same", 1, 32'h99, 1'b0);
        drain();
        tick();
        idle_in();
        push("sb9_after", 1, 32'h99, 1'b1);
        drain();

        // preload 1..31 and mark reg 3 busy
        for (int i = 1; i < NREG; i++) begin
            wa_en = 1'b1; wa_addr = AW'(i); wa_data = 32'h100 + 32'(i);
            tick();
        end
        idle_in();
        sb_set_en = 1'b1; sb_set_addr = 5'd3;
        tick();
        idle_in();
        set_rd(0, 5'd3);
        set_rd(1, 5'd31);
        push("preload_r3", 0, 32'h103, 1'b1);
        push("preload_r31", 1, 32'h11F, 1'b0);
        drain();

        // full clear sequence
        clr_req = 1'b1;
        tick();
        idle_in();
        for (int c = 0; c < NREG - 1; c++) begin
            wa_en = (c == 2) || (c == 3);
            wa_addr = 5'd4; wa_data = 32'hFFFF0004;
            clr_req = (c == 5);
            set_rd(0, AW'(c + 1));
            set_rd(1, AW'(c));
            push("clr_pending", 0, 32'h100 + 32'(c + 1), ((c + 1) == 3) || ((c + 1) == 9));
            push("clr_done_reg", 1, 32'h0, 1'b0);
            drain();
            chk("clr_busy_high", 64'(clr_busy), 64'd1);
            chk("clr_done_low", 64'(clr_done), 64'd0);
            tick();
        end
        idle_in();
        chk("clr_done_pulse", 64'(clr_done), 64'd1);
        chk("clr_busy_drop", 64'(clr_busy), 64'd0);
        tick();
        chk("clr_done_once", 64'(clr_done), 64'd0);
        chk("clr_req_ignored", 64'(clr_busy), 64'd0);
        for (int i = 1; i < NREG; i++) begin
            set_rd(0, AW'(i));
            push("post_clear", 0, 32'h0, 1'b0);
            drain();
        end

        // reset in the middle of a clear
        wa_en = 1'b1; wa_addr = 5'd20; wa_data = 32'h20;
        sb_set_en = 1'b1; sb_set_addr = 5'd20;
        tick();
        idle_in();
        clr_req = 1'b1;
        tick();
        idle_in();
        for (int c = 0; c < 10; c++) tick();
        set_rd(0, 5'd20);
        push("midclr_r20", 0, 32'h20, 1'b1);
        drain();
        rst_n = 1'b0;
        push("rst_midclr_r20", 0, 32'h0, 1'b0);
        drain();
        chk("rst_midclr_busy", 64'(clr_busy), 64'd0);
        chk("rst_midclr_done", 64'(clr_done), 64'd0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_done", 64'(clr_done), 64'd0);
        end

        // restart clears from index 1
        wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'h77;
        tick();
        wa_addr = 5'd2; wa_data = 32'h88;
        tick();
        idle_in();
        clr_req = 1'b1;
        tick();
        idle_in();
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        push("restart_r1_c0", 0, 32'h77, 1'b0);
        push("restart_r2_c0", 1, 32'h88, 1'b0);
        drain();
        tick();
        push("restart_r1_c1", 0, 32'h0, 1'b0);
        push("restart_r2_c1", 1, 32'h88, 1'b0);
        drain();
        k = 1;
        while ((clr_done !== 1'b1) && (k < 60)) begin
            tick();
            k++;
        end
        chk("restart_done_seen", 64'(clr_done), 64'd1);
        chk("restart_length", 64'(k), 64'(NREG - 1));
        a = 5'd2;
        set_rd(1, a);
        push("restart_r2_final", 1, 32'h0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the CPU integer register file.
- Provides NREAD combinational read ports and two write ports:
  - port A: ALU writeback.
  - port B: load/long-latency return.
- Adds optional write-to-read bypass, a per-register busy scoreboard for in-flight long-latency results, and a sequential hardware clear engine.
- Sits between the decode/issue stage (reads, scoreboard set) and the writeback stage (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; register count is 2^ADDR_W.
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NREAD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NREAD*DATA_W  packed read data.
- rd_busy  out  NREAD  scoreboard busy flag per read port.
- wa_en  in  1  write port A enable.
- wa_addr  in  ADDR_W  write port A address.
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B enable; also clears the scoreboard bit.
- wb_addr  in  ADDR_W  write port B address.
- wb_data  in  DATA_W  write port B data.
- sb_set_en  in  1  mark register busy (long-latency op issued).
- sb_set_addr  in  ADDR_W  register to mark busy.
- clr_req  in  1  start hardware clear.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:

Reset (rst_n low, asynchronous):
- All registers and busy bits go to 0.
- FSM goes to IDLE; clr_busy=0, clr_done=0.
- Reset asserted mid-clear aborts the clear immediately; no clr_done pulse.

Reads (combinational, zero latency):
- ZERO_REG=1 and addr 0: rd_data=0, rd_busy=0.
- BYPASS=1 and not CLEAR: if wa_en and wa_addr==rd_addr, return wa_data. Otherwise, if wb_en and wb_addr==rd_addr, return wb_data. Otherwise return the stored value.
- rd_busy = busy[addr], except it reads 0 when BYPASS=1 and wb_en hits the same addr this cycle.
- An sb_set in the same cycle is not visible on rd_busy until the next cycle.

Writes (rising edge, IDLE only):
- Writes to addr 0 are discarded when ZERO_REG=1.
- wa and wb to the same addr in the same cycle: port A data is stored (younger result). Port B still clears the busy bit.

Scoreboard (rising edge, IDLE only):
- sb_set_en sets busy[sb_set_addr].
- wb_en clears busy[wb_addr].
- Set and clear on the same addr in the same cycle: set wins.
- wa_en does not affect busy bits.
- sb_set to addr 0 is ignored when ZERO_REG=1.

Clear FSM (states IDLE, CLEAR):
- IDLE, clr_req=1: go to CLEAR, index=ZERO_REG?1:0, clr_busy=1 from the next cycle.
- CLEAR, each cycle: reg[index]<=0, busy[index]<=0, index++.
- CLEAR, on index==2^ADDR_W-1 (cleared this cycle): go to IDLE, pulse clr_done for 1 cycle, clr_busy drops with it.
- Total clear length: 2^ADDR_W-ZERO_REG cycles (31 at default).
- During CLEAR:
  - wa/wb writes and sb_set are dropped.
  - clr_req is ignored.
  - Bypass is disabled; reads return current stored contents, which may be partially cleared.
- Index counter is ADDR_W bits wide and wraps only at the terminal check; it never re-clears.

Decomposition:
- Shared package regfile_pkg holds:
  - localparam NREG = 2**ADDR_W default.
  - FSM state enum {IDLE, CLEAR}.
  - Helper function for packed-port slicing.
- One sub-module, regfile_clr_fsm, owns the state, index counter, clr_busy and clr_done. It outputs clr_we/clr_idx to the storage array.
- Storage, bypass and scoreboard live in the top module, with one generate loop over read ports.

Test Plan:
- Reset: rst_n=0 mid-run → all rd_data=0, rd_busy=0, clr_busy=0 immediately without a clock edge.
- Dual write collision: wa (addr 5, 0xAAAA0000) and wb (addr 5, 0x5555FFFF) same cycle → next cycle reg5 reads 0xAAAA0000; with BYPASS=1 the same-cycle read also returns 0xAAAA0000.
- Zero register: wa_en addr 0 data 0xDEADBEEF plus sb_set addr 0 → rd_addr 0 returns 0, rd_busy=0.
- Scoreboard:
  - sb_set addr 7 → rd_busy on addr 7 is 1 from the next cycle.
  - wb addr 7 data 0x12 → same-cycle rd_busy=0 and rd_data=0x12 (BYPASS=1).
  - Simultaneous sb_set and wb on addr 9 → busy[9]=1 afterwards.
- Clear:
  - Preload regs 1..31 with index values, set busy on 3, pulse clr_req → clr_busy high for 31 cycles, regs zeroed in ascending order, clr_done pulses once, all busy=0.
  - A wa write to addr 4 during CLEAR is dropped.
- Reset mid-clear: assert rst_n=0 after 10 clear cycles → IDLE, all zero, no clr_done. A later clr_req restarts from index 1.
